// File: rtl/uart_pkg.sv
// Shared UART definitions: link FSM state encoding, line-level constants and default payload width.
// Shared by the transmitter and the receiver so both ends agree on encodings.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    localparam int DEFAULT_DATA_WIDTH = 8;

endpackage

// File: rtl/uart_tx_baud_cnt.sv
// Bit-period counter: counts 0..prescale while enabled, pulses bit_done_o combinationally on the last count.
// Latency: bit_done_o is valid in the same cycle as the matching count; no backpressure.
module uart_tx_baud_cnt #(
    parameter int PRESCALE_WIDTH = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      clear_i,
    input  logic                      enable_i,
    input  logic [PRESCALE_WIDTH-1:0] prescale_i,
    output logic                      bit_done_o
);

    logic [PRESCALE_WIDTH-1:0] cnt_q;
    logic [PRESCALE_WIDTH-1:0] cnt_d;

    assign bit_done_o = enable_i && (cnt_q == prescale_i);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = bit_done_o ? '0 : cnt_q + PRESCALE_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, LSB-first data, optional parity, stop; 1-cycle accept latency, requests while busy are dropped.
// Define UART_TX_TWO_STOP_EN to send two stop bits per frame.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int PRESCALE_WIDTH = 5
) (
    input  logic                      UartTx_CLK,
    input  logic                      UartTx_RST,
    input  logic [PRESCALE_WIDTH-1:0] UartTx_prescale,
    input  logic [DATA_WIDTH-1:0]     UartTx_PDATA,
    input  logic                      UartTx_Data_Valid,
    input  logic                      UartTx_PAR_EN,
    input  logic                      UartTx_Par_Type,
    output logic                      UartTx_TX_OUT,
    output logic                      UartTx_Busy
);

    localparam int IDX_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    uart_state_e               state_q, state_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
    logic                      par_en_q, par_en_d;
    logic                      par_type_q, par_type_d;
    logic [IDX_W-1:0]          bit_idx_q, bit_idx_d;
    logic                      tx_q, tx_d;
    logic                      busy_q, busy_d;
    logic                      bit_done;

    uart_tx_baud_cnt #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_baud_cnt (
        .clk_i      (UartTx_CLK),
        .rst_n_i    (UartTx_RST),
        .clear_i    (state_q == ST_IDLE),
        .enable_i   (state_q != ST_IDLE),
        .prescale_i (prescale_q),
        .bit_done_o (bit_done)
    );

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        prescale_d = prescale_q;
        par_en_d   = par_en_q;
        par_type_d = par_type_q;
        bit_idx_d  = bit_idx_q;

        case (state_q)
            ST_IDLE: begin
                if (UartTx_Data_Valid) begin
                    data_d     = UartTx_PDATA;
                    prescale_d = UartTx_prescale;
                    par_en_d   = UartTx_PAR_EN;
                    par_type_d = UartTx_Par_Type;
                    bit_idx_d  = '0;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    bit_idx_d = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    if (bit_idx_q == LAST_IDX) begin
                        bit_idx_d = '0;
                        state_d   = par_en_q ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (bit_done) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
`ifdef UART_TX_TWO_STOP_EN
                    // bit_idx is free during STOP; reuse it to count the two stop periods
                    if (bit_idx_q == '0) begin
                        bit_idx_d = IDX_W'(1);
                    end else begin
                        bit_idx_d = '0;
                        state_d   = ST_IDLE;
                    end
`else
                    state_d = ST_IDLE;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Line level is decoded from the next state so TX_OUT comes straight off a flop
    always_comb begin
        tx_d   = STOP_BIT;
        busy_d = (state_d != ST_IDLE);
        case (state_d)
            ST_START:  tx_d = START_BIT;
            ST_DATA:   tx_d = data_d[bit_idx_d];
            ST_PARITY: tx_d = (^data_d) ^ par_type_d;
            default:   tx_d = STOP_BIT;
        endcase
    end

    always_ff @(posedge UartTx_CLK) begin
        if (!UartTx_RST) begin
            state_q    <= ST_IDLE;
            data_q     <= '0;
            prescale_q <= '0;
            par_en_q   <= 1'b0;
            par_type_q <= PAR_EVEN;
            bit_idx_q  <= '0;
            tx_q       <= STOP_BIT;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            prescale_q <= prescale_d;
            par_en_q   <= par_en_d;
            par_type_q <= par_type_d;
            bit_idx_q  <= bit_idx_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

    assign UartTx_TX_OUT = tx_q;
    assign UartTx_Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frame shape, parity, mid-frame input changes, reset abort, back-to-back frames.
// Expected frames are built from hand-computed parity values and the literal frame layout.
module tb_uart_tx;

    logic       clk;
    logic       rst;
    logic [4:0] prescale;
    logic [7:0] pdata;
    logic       data_valid;
    logic       par_en;
    logic       par_type;
    logic       tx_out;
    logic       busy;

    int vectors;
    int miscompares;

`ifdef UART_TX_TWO_STOP_EN
    localparam int N_STOP = 2;
`else
    localparam int N_STOP = 1;
`endif

    uart_tx dut (
        .UartTx_CLK        (clk),
        .UartTx_RST        (rst),
        .UartTx_prescale   (prescale),
        .UartTx_PDATA      (pdata),
        .UartTx_Data_Valid (data_valid),
        .UartTx_PAR_EN     (par_en),
        .UartTx_Par_Type   (par_type),
        .UartTx_TX_OUT     (tx_out),
        .UartTx_Busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Present a request for exactly one accept edge, leaving valid as given afterwards.
    task automatic request(input logic [7:0] d, input logic [4:0] pre, input logic pen,
                           input logic ptype, input logic hold_valid);
        pdata      = d;
        prescale   = pre;
        par_en     = pen;
        par_type   = ptype;
        data_valid = 1'b1;
        tick();
        data_valid = hold_valid;
    endtask

    // Called one step after the accept edge; walks the whole frame cycle by cycle,
    // then checks the first idle cycle. disturb fires junk inputs during data bit 2.
    task automatic check_frame(input string name, input logic [7:0] d, input int pre,
                               input logic pen, input logic par_exp, input logic disturb);
        int   nbits;
        logic exp_bit;
        nbits = 10 + (pen ? 1 : 0) + (N_STOP - 1);
        for (int k = 0; k < nbits; k++) begin
            if (k == 0)                 exp_bit = 1'b0;
            else if (k <= 8)            exp_bit = d[k-1];
            else if (pen && k == 9)     exp_bit = par_exp;
            else                        exp_bit = 1'b1;
            for (int c = 0; c <= pre; c++) begin
                chk($sformatf("%s bit%0d cyc%0d tx", name, k, c), tx_out, exp_bit);
                chk($sformatf("%s bit%0d cyc%0d busy", name, k, c), busy, 1'b1);
                if (disturb && k == 3 && c == 0) begin
                    pdata      = 8'hFF;
                    prescale   = 5'd2;
                    par_type   = ~par_type;
                    par_en     = ~par_en;
                    data_valid = 1'b1;
                end else if (disturb && k == 3 && c == 1) begin
                    data_valid = 1'b0;
                end
                tick();
            end
        end
        chk($sformatf("%s idle tx", name), tx_out, 1'b1);
        chk($sformatf("%s idle busy", name), busy, 1'b0);
    endtask

    task automatic idle_cycles(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk($sformatf("%s idle%0d tx", name, i), tx_out, 1'b1);
            chk($sformatf("%s idle%0d busy", name, i), busy, 1'b0);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        prescale    = 5'd0;
        pdata       = 8'h00;
        data_valid  = 1'b0;
        par_en      = 1'b0;
        par_type    = 1'b0;

        // Reset state
        tick();
        tick();
        chk("reset tx", tx_out, 1'b1);
        chk("reset busy", busy, 1'b0);
        rst = 1'b1;
        idle_cycles("post_reset", 2);

        // 0x55 has four ones: even parity 0, odd parity 1
        request(8'h55, 5'd7, 1'b1, 1'b0, 1'b0);
        check_frame("p55_even", 8'h55, 7, 1'b1, 1'b0, 1'b0);
        idle_cycles("p55_even", 1);

        request(8'h55, 5'd7, 1'b1, 1'b1, 1'b0);
        check_frame("p55_odd", 8'h55, 7, 1'b1, 1'b1, 1'b0);
        idle_cycles("p55_odd", 1);

        // 0x07 has three ones: even parity 1
        request(8'h07, 5'd7, 1'b1, 1'b0, 1'b0);
        check_frame("p07_even", 8'h07, 7, 1'b1, 1'b1, 1'b0);
        idle_cycles("p07_even", 1);

        // No parity, 16-cycle bits
        request(8'hA3, 5'd15, 1'b0, 1'b0, 1'b0);
        check_frame("pA3_nopar", 8'hA3, 15, 1'b0, 1'b0, 1'b0);
        idle_cycles("pA3_nopar", 1);

        // Mid-frame request and config changes must not affect the frame; 0xFF never follows
        request(8'h55, 5'd7, 1'b1, 1'b0, 1'b0);
        check_frame("disturb", 8'h55, 7, 1'b1, 1'b0, 1'b1);
        idle_cycles("disturb", 4);

        // Reset during data bit 3 of an all-zero frame (prescale 3: bit 3 starts 16 cycles in)
        request(8'h00, 5'd3, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 17; i++) tick();
        chk("abort in bit3 tx", tx_out, 1'b0);
        chk("abort in bit3 busy", busy, 1'b1);
        rst = 1'b0;
        tick();
        chk("abort reset tx", tx_out, 1'b1);
        chk("abort reset busy", busy, 1'b0);
        rst = 1'b1;
        idle_cycles("abort", 3);
        request(8'hC6, 5'd3, 1'b1, 1'b1, 1'b0);
        // 0xC6 has four ones: odd parity 1
        check_frame("after_abort", 8'hC6, 3, 1'b1, 1'b1, 1'b0);
        idle_cycles("after_abort", 1);

        // Prescale 0 with valid held: frames separated by exactly one idle cycle
        request(8'h3C, 5'd0, 1'b0, 1'b0, 1'b1);
        check_frame("b2b_first", 8'h3C, 0, 1'b0, 1'b0, 1'b0);
        pdata = 8'h81;
        tick();
        check_frame("b2b_second", 8'h81, 0, 1'b0, 1'b0, 1'b0);
        data_valid = 1'b0;
        idle_cycles("b2b_end", 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
